// File: rtl/vga_timing_if.sv
// Video timing bundle from the raster generator to the renderer and sprite layers.
interface vga_timing_if;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic       video_active;
   logic       hsync;
   logic       vsync;
   logic       line_start;
   logic       frame_start;

   modport master (
      output pix_x, pix_y, video_active, hsync, vsync, line_start, frame_start
   );

   modport slave (
      input  pix_x, pix_y, video_active, hsync, vsync, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical counters advanced by pix_ce,
// with every output registered from the decode of the pre-increment counters
// so all outputs stay mutually aligned one ce cycle behind the counters.
module vga_timing_gen #(
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pix_ce,
   vga_timing_if.master vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);

   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_BEGIN = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic [9:0]  pix_x_q, pix_x_d;
   logic [9:0]  pix_y_q, pix_y_d;
   logic        video_active_q, video_active_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        line_start_q, line_start_d;
   logic        frame_start_q, frame_start_d;

   logic        h_vis_s;
   logic        v_vis_s;
   logic        h_sync_s;
   logic        v_sync_s;

   // Decode the current counter position into visibility and sync windows.
   always_comb begin
      h_vis_s  = (h_cnt_q < H_VIS);
      v_vis_s  = (v_cnt_q < V_VIS);
      h_sync_s = (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
      v_sync_s = (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);
   end

   // Next-state: advance counters and capture decoded outputs on ce; strobes self-clear.
   always_comb begin
      h_cnt_d        = h_cnt_q;
      v_cnt_d        = v_cnt_q;
      pix_x_d        = pix_x_q;
      pix_y_d        = pix_y_q;
      video_active_d = video_active_q;
      hsync_d        = hsync_q;
      vsync_d        = vsync_q;
      line_start_d   = 1'b0;
      frame_start_d  = 1'b0;

      if (pix_ce) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = 11'd0;
            if (v_cnt_q == V_LAST) begin
               v_cnt_d = 10'd0;
            end else begin
               v_cnt_d = v_cnt_q + 10'd1;
            end
         end else begin
            h_cnt_d = h_cnt_q + 11'd1;
         end

         video_active_d = h_vis_s && v_vis_s;
         pix_x_d        = h_vis_s ? h_cnt_q[9:0] : 10'd0;
         pix_y_d        = v_cnt_q;
         hsync_d        = h_sync_s ? SYNC_POL : ~SYNC_POL;
         // v_cnt only changes at the line wrap, so vsync moves only at h=0.
         vsync_d        = v_sync_s ? SYNC_POL : ~SYNC_POL;
         line_start_d   = (h_cnt_q == 11'd0);
         frame_start_d  = (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);
      end else begin
         h_cnt_d = h_cnt_q;
         v_cnt_d = v_cnt_q;
      end
   end

   // State and output registers with synchronous reset overriding pix_ce.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q        <= 11'd0;
         v_cnt_q        <= 10'd0;
         pix_x_q        <= 10'd0;
         pix_y_q        <= 10'd0;
         video_active_q <= 1'b0;
         hsync_q        <= ~SYNC_POL;
         vsync_q        <= ~SYNC_POL;
         line_start_q   <= 1'b0;
         frame_start_q  <= 1'b0;
      end else begin
         h_cnt_q        <= h_cnt_d;
         v_cnt_q        <= v_cnt_d;
         pix_x_q        <= pix_x_d;
         pix_y_q        <= pix_y_d;
         video_active_q <= video_active_d;
         hsync_q        <= hsync_d;
         vsync_q        <= vsync_d;
         line_start_q   <= line_start_d;
         frame_start_q  <= frame_start_d;
      end
   end

   assign vid.pix_x        = pix_x_q;
   assign vid.pix_y        = pix_y_q;
   assign vid.video_active = video_active_q;
   assign vid.hsync        = hsync_q;
   assign vid.vsync        = vsync_q;
   assign vid.line_start   = line_start_q;
   assign vid.frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 1024x768 instance and a
// small-parameter instance with active-high sync.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_a, ce_a, rst_b, ce_b;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   vga_timing_if vid_a ();
   vga_timing_if vid_b ();

   vga_timing_gen dut_a (
      .clk    (clk),
      .rst    (rst_a),
      .pix_ce (ce_a),
      .vid    (vid_a)
   );

   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .SYNC_POL (1'b1)
   ) dut_b (
      .clk    (clk),
      .rst    (rst_b),
      .pix_ce (ce_b),
      .vid    (vid_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(string tag,
                          logic [9:0] ox, logic [9:0] oy, logic ova, logic ohs,
                          logic ovs, logic ols, logic ofs,
                          int ex, int ey, int eva, int ehs, int evs, int els, int efs);
      chk({tag, ".pix_x"},        {22'd0, ox},  32'(ex));
      chk({tag, ".pix_y"},        {22'd0, oy},  32'(ey));
      chk({tag, ".video_active"}, {31'd0, ova}, 32'(eva));
      chk({tag, ".hsync"},        {31'd0, ohs}, 32'(ehs));
      chk({tag, ".vsync"},        {31'd0, ovs}, 32'(evs));
      chk({tag, ".line_start"},   {31'd0, ols}, 32'(els));
      chk({tag, ".frame_start"},  {31'd0, ofs}, 32'(efs));
   endtask

   initial begin
      int h, v, ha, hs_low, va_cnt;

      rst_a = 1'b1; ce_a = 1'b1;
      rst_b = 1'b1; ce_b = 1'b1;
      repeat (3) tick();

      // Reset state of the default instance (active-low sync idles high).
      chk_all("a_reset", vid_a.pix_x, vid_a.pix_y, vid_a.video_active, vid_a.hsync,
              vid_a.vsync, vid_a.line_start, vid_a.frame_start, 0, 0, 0, 1, 1, 0, 0);

      // Continuous ce: line 0 fully, then into line 1 up to h=500.
      rst_a = 1'b0;
      hs_low = 0; va_cnt = 0;
      for (int k = 1; k <= 1845; k++) begin
         tick();
         ha = k - 1;
         h  = ha % 1344;
         v  = ha / 1344;
         chk_all($sformatf("a_run k=%0d", k), vid_a.pix_x, vid_a.pix_y, vid_a.video_active,
                 vid_a.hsync, vid_a.vsync, vid_a.line_start, vid_a.frame_start,
                 (h < 1024) ? h : 0, v, (h < 1024) ? 1 : 0,
                 (h >= 1048 && h < 1184) ? 0 : 1, 1,
                 (h == 0) ? 1 : 0, (h == 0 && v == 0) ? 1 : 0);
         if (v == 0 && vid_a.hsync === 1'b0) hs_low++;
         if (v == 0 && vid_a.video_active === 1'b1) va_cnt++;
      end
      chk("a_hsync_low_clks", 32'(hs_low), 32'd136);
      chk("a_active_clks",    32'(va_cnt), 32'd1024);

      // Mid-line reset at (h=500, v=1): outputs return to reset values next cycle.
      rst_a = 1'b1;
      tick();
      chk_all("a_midreset", vid_a.pix_x, vid_a.pix_y, vid_a.video_active, vid_a.hsync,
              vid_a.vsync, vid_a.line_start, vid_a.frame_start, 0, 0, 0, 1, 1, 0, 0);
      rst_a = 1'b0;
      tick();
      chk_all("a_restart", vid_a.pix_x, vid_a.pix_y, vid_a.video_active, vid_a.hsync,
              vid_a.vsync, vid_a.line_start, vid_a.frame_start, 0, 0, 1, 1, 1, 1, 1);
      ce_a = 1'b0;
      tick();
      chk_all("a_ce_hold", vid_a.pix_x, vid_a.pix_y, vid_a.video_active, vid_a.hsync,
              vid_a.vsync, vid_a.line_start, vid_a.frame_start, 0, 0, 1, 1, 1, 0, 0);

      // Half-rate ce: every timing doubles, strobes stay one clock wide.
      rst_a = 1'b1; ce_a = 1'b1;
      tick();
      rst_a = 1'b0;
      for (int n = 1; n <= 2690; n++) begin
         ce_a = (n % 2 == 1) ? 1'b1 : 1'b0;
         tick();
         ha = (n - 1) / 2;
         h  = ha % 1344;
         v  = ha / 1344;
         chk_all($sformatf("a_half n=%0d", n), vid_a.pix_x, vid_a.pix_y, vid_a.video_active,
                 vid_a.hsync, vid_a.vsync, vid_a.line_start, vid_a.frame_start,
                 (h < 1024) ? h : 0, v, (h < 1024) ? 1 : 0,
                 (h >= 1048 && h < 1184) ? 0 : 1, 1,
                 (h == 0 && n % 2 == 1) ? 1 : 0,
                 (h == 0 && v == 0 && n % 2 == 1) ? 1 : 0);
      end

      // Small instance: reset values with active-high sync idling low.
      chk_all("b_reset", vid_b.pix_x, vid_b.pix_y, vid_b.video_active, vid_b.hsync,
              vid_b.vsync, vid_b.line_start, vid_b.frame_start, 0, 0, 0, 0, 0, 0, 0);

      // Two full 14x7 frames plus wrap into a third.
      rst_b = 1'b0;
      for (int k = 1; k <= 198; k++) begin
         tick();
         ha = k - 1;
         h  = ha % 14;
         v  = (ha / 14) % 7;
         chk_all($sformatf("b_run k=%0d", k), vid_b.pix_x, vid_b.pix_y, vid_b.video_active,
                 vid_b.hsync, vid_b.vsync, vid_b.line_start, vid_b.frame_start,
                 (h < 8) ? h : 0, v, (h < 8 && v < 4) ? 1 : 0,
                 (h == 10 || h == 11) ? 1 : 0, (v == 5) ? 1 : 0,
                 (h == 0) ? 1 : 0, (h == 0 && v == 0) ? 1 : 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
